memory_arbiter: RTL and testbench

//   Shares one unified memory between the instruction-fetch port and the data port of the

---
 rtl/memory_arbiter.sv | 139 +++++++++++++
 tb/tb_memory_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Shares one unified memory between the instruction-fetch and data ports of the RV64I core.
// Each port's request is latched, then requests are served one at a time, alternating on ties.
module memory_arbiter #(
    parameter int ADDR_SIZE = 64,
    parameter int DATA_SIZE = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inst_enable,
    input  logic [ADDR_SIZE-1:0]   inst_addr,
    output logic [31:0]            inst_data,
    output logic                   inst_busy,
    input  logic                   data_enable,
    input  logic [ADDR_SIZE-1:0]   data_addr,
    input  logic [DATA_SIZE/8-1:0] data_byte_write_enable,
    input  logic [DATA_SIZE-1:0]   data_write_data,
    output logic [DATA_SIZE-1:0]   data_read_data,
    output logic                   data_busy,
    output logic                   mem_enable,
    output logic [ADDR_SIZE-1:0]   mem_addr,
    output logic [DATA_SIZE/8-1:0] mem_byte_write_enable,
    output logic [DATA_SIZE-1:0]   mem_write_data,
    input  logic [DATA_SIZE-1:0]   mem_read_data,
    input  logic                   mem_busy
);

    localparam int BWE_SIZE = DATA_SIZE / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RISE, WAIT_FALL} state_t;
    typedef enum logic {GRANT_INST, GRANT_DATA} grant_t;

    state_t state, state_next;
    grant_t last_grant, active_grant, grant_sel;
    logic grant_valid, complete;

    logic [ADDR_SIZE-1:0] inst_addr_q, data_addr_q;
    logic [BWE_SIZE-1:0]  data_bwe_q, issue_bwe;
    logic [DATA_SIZE-1:0] data_wdata_q;

    // A busy port that is not in service is exactly a pending request, so IDLE arbitrates on busy flags.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_sel   = GRANT_INST;
        complete    = 1'b0;
        case (state)
            IDLE: begin
                if (inst_busy && data_busy) begin
                    grant_sel = (last_grant == GRANT_INST) ? GRANT_DATA : GRANT_INST;
                end else if (data_busy) begin
                    grant_sel = GRANT_DATA;
                end
                grant_valid = inst_busy || data_busy;
                if (grant_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (mem_busy) begin
                    state_next = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                if (!mem_busy) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_enable            = (state == ISSUE);
    assign mem_byte_write_enable = mem_enable ? issue_bwe : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= GRANT_INST;
            active_grant   <= GRANT_INST;
            inst_busy      <= 1'b0;
            data_busy      <= 1'b0;
            inst_addr_q    <= '0;
            data_addr_q    <= '0;
            data_bwe_q     <= '0;
            data_wdata_q   <= '0;
            issue_bwe      <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            inst_data      <= '0;
            data_read_data <= '0;
        end else begin
            state <= state_next;

            if (inst_enable && !inst_busy) begin
                inst_addr_q <= inst_addr;
                inst_busy   <= 1'b1;
            end
            if (data_enable && !data_busy) begin
                data_addr_q  <= data_addr;
                data_bwe_q   <= data_byte_write_enable;
                data_wdata_q <= data_write_data;
                data_busy    <= 1'b1;
            end

            // Store data is only reloaded by data grants; a fetch leaves the last store value in place.
            if (grant_valid) begin
                last_grant   <= grant_sel;
                active_grant <= grant_sel;
                if (grant_sel == GRANT_DATA) begin
                    mem_addr       <= data_addr_q;
                    mem_write_data <= data_wdata_q;
                    issue_bwe      <= data_bwe_q;
                end else begin
                    mem_addr  <= inst_addr_q;
                    issue_bwe <= '0;
                end
            end

            if (complete) begin
                if (active_grant == GRANT_INST) begin
                    inst_data <= inst_addr_q[2] ? mem_read_data[63:32] : mem_read_data[31:0];
                    inst_busy <= 1'b0;
                end else begin
                    if (data_bwe_q == '0) begin
                        data_read_data <= mem_read_data;
                    end
                    data_busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a behavioural memory plus a queue of expected memory accesses
// in grant order, checked as each mem_enable pulse appears.
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inst_enable = 1'b0;
    logic [63:0] inst_addr = '0;
    logic [31:0] inst_data;
    logic        inst_busy;
    logic        data_enable = 1'b0;
    logic [63:0] data_addr = '0;
    logic [7:0]  data_byte_write_enable = '0;
    logic [63:0] data_write_data = '0;
    logic [63:0] data_read_data;
    logic        data_busy;
    logic        mem_enable;
    logic [63:0] mem_addr;
    logic [7:0]  mem_byte_write_enable;
    logic [63:0] mem_write_data;
    logic [63:0] mem_read_data;
    logic        mem_busy;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  bwe;
        logic [63:0] wdata;
    } access_t;

    access_t expected_q[$];
    access_t mon_e;
    int tests_run = 0;
    int tests_failed = 0;
    int access_count = 0;
    int mem_latency = 3;
    int busy_cnt;

    memory_arbiter #(.ADDR_SIZE(64), .DATA_SIZE(64)) dut (
        .clock(clock),
        .reset(reset),
        .inst_enable(inst_enable),
        .inst_addr(inst_addr),
        .inst_data(inst_data),
        .inst_busy(inst_busy),
        .data_enable(data_enable),
        .data_addr(data_addr),
        .data_byte_write_enable(data_byte_write_enable),
        .data_write_data(data_write_data),
        .data_read_data(data_read_data),
        .data_busy(data_busy),
        .mem_enable(mem_enable),
        .mem_addr(mem_addr),
        .mem_byte_write_enable(mem_byte_write_enable),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .mem_busy(mem_busy)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a[63:3] == '0) return 64'hAAAABBBB_CCCCDDDD;
        return {32'hD000_0000 | a[31:0], ~a[31:0]};
    endfunction

    // Memory answers each strobe with mem_busy high for mem_latency cycles, data valid as busy falls.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_busy      <= 1'b0;
            busy_cnt      <= 0;
            mem_read_data <= '0;
        end else if (mem_enable) begin
            mem_busy      <= 1'b1;
            busy_cnt      <= mem_latency;
            mem_read_data <= mem_word(mem_addr);
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt <= 0;
            mem_busy <= 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ie, input logic [63:0] ia, input logic de,
                                 input logic [63:0] da, input logic [7:0] bwe, input logic [63:0] wd);
        inst_enable            = ie;
        inst_addr              = ia;
        data_enable            = de;
        data_addr              = da;
        data_byte_write_enable = bwe;
        data_write_data        = wd;
    endtask

    task automatic push_expected(input logic [63:0] a, input logic [7:0] b, input logic [63:0] w);
        access_t e;
        e.addr  = a;
        e.bwe   = b;
        e.wdata = w;
        expected_q.push_back(e);
    endtask

    // Each strobe must match the oldest outstanding expected access.
    always @(negedge clock) begin
        if (!reset && mem_enable) begin
            access_count++;
            if (expected_q.size() > 0) mon_e = expected_q.pop_front();
            else mon_e = '{addr: 'x, bwe: 'x, wdata: 'x};
            checkOutput("access_addr", mem_addr, mon_e.addr);
            checkOutput("access_bwe", {56'b0, mem_byte_write_enable}, {56'b0, mon_e.bwe});
            if (mon_e.bwe != 8'h00) checkOutput("access_wdata", mem_write_data, mon_e.wdata);
        end
    end

    task automatic wait_free(input int limit, output int inst_hi, output int data_hi,
                             output int inst_fall, output int data_fall,
                             output int bwe_issue, output int bwe_stray);
        inst_hi = 0; data_hi = 0; inst_fall = -1; data_fall = -1; bwe_issue = 0; bwe_stray = 0;
        for (int c = 0; c < limit; c++) begin
            if (inst_busy) inst_hi++; else if (inst_fall < 0) inst_fall = c;
            if (data_busy) data_hi++; else if (data_fall < 0) data_fall = c;
            if (mem_byte_write_enable != 8'h00) begin
                if (mem_enable) bwe_issue++; else bwe_stray++;
            end
            if (!inst_busy && !data_busy) return;
            @(negedge clock);
        end
        checkOutput("wait_timeout", {62'b0, inst_busy, data_busy}, 64'h0);
    endtask

    task automatic check_all_zero(input string phase);
        checkOutput({phase, "_inst_busy"}, {63'b0, inst_busy}, 64'h0);
        checkOutput({phase, "_data_busy"}, {63'b0, data_busy}, 64'h0);
        checkOutput({phase, "_mem_enable"}, {63'b0, mem_enable}, 64'h0);
        checkOutput({phase, "_mem_bwe"}, {56'b0, mem_byte_write_enable}, 64'h0);
        checkOutput({phase, "_inst_data"}, {32'b0, inst_data}, 64'h0);
        checkOutput({phase, "_data_read_data"}, data_read_data, 64'h0);
        checkOutput({phase, "_mem_addr"}, mem_addr, 64'h0);
        checkOutput({phase, "_mem_write_data"}, mem_write_data, 64'h0);
    endtask

    initial begin
        int ih, dh, ifall, dfall, bi, bs, start, i_reqs, d_reqs;
        logic [63:0] w;

        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        // Single fetch of the upper instruction word.
        @(negedge clock);
        start = access_count;
        push_expected(64'h4, 8'h00, 64'h0);
        applyStimulus(1'b1, 64'h4, 1'b0, 64'h0, 8'h00, 64'h0);
        @(negedge clock);
        inst_enable = 1'b0;
        wait_free(50, ih, dh, ifall, dfall, bi, bs);
        checkOutput("fetch_busy_cycles", ih, 6);
        checkOutput("fetch_inst_data", {32'b0, inst_data}, 64'h0000_0000_AAAABBBB);
        checkOutput("fetch_pulses", access_count - start, 1);

        // Simultaneous requests after reset: data wins the tie.
        push_expected(64'h100, 8'h00, 64'h0);
        push_expected(64'h0, 8'h00, 64'h0);
        applyStimulus(1'b1, 64'h0, 1'b1, 64'h100, 8'h00, 64'h0);
        @(negedge clock);
        inst_enable = 1'b0;
        data_enable = 1'b0;
        wait_free(100, ih, dh, ifall, dfall, bi, bs);
        checkOutput("tie_data_first", {63'b0, (dfall >= 0) && (dfall < ifall)}, 64'h1);
        checkOutput("tie_data_read", data_read_data, mem_word(64'h100));
        checkOutput("tie_inst_data", {32'b0, inst_data}, 64'h0000_0000_CCCCDDDD);

        // Partial store: strobe only during ISSUE, load data untouched.
        push_expected(64'h180, 8'h0F, 64'h1122334455667788);
        applyStimulus(1'b0, 64'h0, 1'b1, 64'h180, 8'h0F, 64'h1122334455667788);
        @(negedge clock);
        data_enable = 1'b0;
        data_byte_write_enable = 8'h00;
        wait_free(50, ih, dh, ifall, dfall, bi, bs);
        checkOutput("store_bwe_issue", bi, 1);
        checkOutput("store_bwe_stray", bs, 0);
        checkOutput("store_busy_cycles", dh, 6);
        checkOutput("store_read_kept", data_read_data, mem_word(64'h100));

        // Enable and address churn while busy must not disturb the latched fetch.
        mem_latency = 2;
        start = access_count;
        push_expected(64'h40, 8'h00, 64'h0);
        applyStimulus(1'b1, 64'h40, 1'b0, 64'h0, 8'h00, 64'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            inst_enable = 1'($urandom_range(0, 1));
            inst_addr   = {$urandom, $urandom};
        end
        @(negedge clock);
        inst_enable = 1'b0;
        wait_free(50, ih, dh, ifall, dfall, bi, bs);
        w = mem_word(64'h40);
        checkOutput("ignore_inst_data", {32'b0, inst_data}, {32'b0, w[31:0]});
        checkOutput("ignore_pulses", access_count - start, 1);

        // Reset in the middle of a data read abandons it and clears every output.
        mem_latency = 6;
        start = access_count;
        push_expected(64'h300, 8'h00, 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b1, 64'h300, 8'h00, 64'h0);
        @(negedge clock);
        data_enable = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mem_busy) break;
            @(negedge clock);
        end
        checkOutput("reset_mem_busy_seen", {63'b0, mem_busy}, 64'h1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        checkOutput("post_reset_no_enable", access_count - start, 1);

        // Both ports re-request as soon as they are free: grants alternate D,I,D,I...
        mem_latency = 1;
        start = access_count;
        for (int k = 0; k < 4; k++) begin
            push_expected(64'h200 + 64'(8 * k), 8'h00, 64'h0);
            push_expected(64'h1000 + 64'(4 * k), 8'h00, 64'h0);
        end
        applyStimulus(1'b1, 64'h1000, 1'b1, 64'h200, 8'h00, 64'h0);
        i_reqs = 1;
        d_reqs = 1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            if (inst_busy) inst_enable = 1'b0;
            if (data_busy) data_enable = 1'b0;
            if (!inst_busy && !inst_enable && i_reqs < 4) begin
                inst_enable = 1'b1;
                inst_addr   = 64'h1000 + 64'(4 * i_reqs);
                i_reqs++;
            end
            if (!data_busy && !data_enable && d_reqs < 4) begin
                data_enable = 1'b1;
                data_addr   = 64'h200 + 64'(8 * d_reqs);
                d_reqs++;
            end
            if (i_reqs == 4 && d_reqs == 4 && !inst_enable && !data_enable && !inst_busy && !data_busy) break;
        end
        checkOutput("fair_access_count", access_count - start, 8);
        checkOutput("fair_inst_data", {32'b0, inst_data}, 64'h0000_0000_D000100C);
        checkOutput("fair_data_read", data_read_data, mem_word(64'h218));
        checkOutput("queue_drained", expected_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
